// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared BIP constants: opcodes, accumulator select and ALU op encodings
package bip_pkg;

    typedef enum logic [4:0] {
        HLT  = 5'd0,
        STO  = 5'd1,
        LD   = 5'd2,
        LDI  = 5'd3,
        ADD  = 5'd4,
        ADDI = 5'd5,
        SUB  = 5'd6,
        SUBI = 5'd7
    } bip_opcode_e;

    localparam logic [1:0] SEL_A_MEM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bip_data_memory.sv
// rtl/bip_data_memory.sv - single-port data RAM, asynchronous read, synchronous write
// Ports: i_clk clock; i_we write enable; i_rd read enable; i_addr word address;
//        i_wdata write data; o_rdata read data (0 when not reading or out of range).
module bip_data_memory #(
    parameter int NB_DATA   = 16,
    parameter int NB_ADDR   = 11,
    parameter int RAM_DEPTH = 2048
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic               i_rd,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic [NB_DATA-1:0] o_rdata
);

    localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [NB_DATA-1:0] mem_q [RAM_DEPTH];
    logic               in_range;
    logic [IDX_W-1:0]   idx;

    assign in_range = ({{(32-NB_ADDR){1'b0}}, i_addr} < 32'(RAM_DEPTH));
    assign idx      = i_addr[IDX_W-1:0];

    // Read is combinational, so a same-cycle write is seen only after the edge.
    assign o_rdata = (i_rd && in_range) ? mem_q[idx] : '0;

    always_ff @(posedge i_clk) begin
        if (i_we && in_range) begin
            mem_q[idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/bip_datapath.sv
// rtl/bip_datapath.sv - BIP execution datapath: accumulator, add/sub ALU, flags, data RAM
// Ports: i_clk, i_rst (sync, active high); i_operand immediate/address;
//        i_selA acc source, i_selB ALU B source, i_wrAcc, i_op, i_wrRam, i_rdRam strobes;
//        o_acc accumulator; o_zero, o_neg, o_ovf registered status flags.
module bip_datapath
    import bip_pkg::*;
#(
    parameter int NB_DATA          = 16,
    parameter int NB_ADDR          = 11,
    parameter int NB_DECODER_SEL_A = 2,
    parameter int RAM_DEPTH        = 2048
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NB_ADDR-1:0]          i_operand,
    input  logic [NB_DECODER_SEL_A-1:0] i_selA,
    input  logic                        i_selB,
    input  logic                        i_wrAcc,
    input  logic                        i_op,
    input  logic                        i_wrRam,
    input  logic                        i_rdRam,
    output logic [NB_DATA-1:0]          o_acc,
    output logic                        o_zero,
    output logic                        o_neg,
    output logic                        o_ovf
);

    localparam int MSB = NB_DATA - 1;

    logic [NB_DATA-1:0] acc_q, acc_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;

    logic [NB_DATA-1:0] imm;
    logic [NB_DATA-1:0] mem_data;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_DATA-1:0] alu_res;
    logic               alu_ovf;
    logic               acc_wr;

    assign imm = {{(NB_DATA-NB_ADDR){i_operand[NB_ADDR-1]}}, i_operand};

    // Reset cycles must never disturb RAM contents.
    bip_data_memory #(
        .NB_DATA   (NB_DATA),
        .NB_ADDR   (NB_ADDR),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_data_memory (
        .i_clk   (i_clk),
        .i_we    (i_wrRam & ~i_rst),
        .i_rd    (i_rdRam),
        .i_addr  (i_operand),
        .i_wdata (acc_q),
        .o_rdata (mem_data)
    );

    always_comb begin
        alu_b = i_selB ? imm : mem_data;
        if (i_op == OP_SUB) begin
            alu_res = acc_q - alu_b;
            alu_ovf = (acc_q[MSB] != alu_b[MSB]) && (alu_res[MSB] != acc_q[MSB]);
        end else begin
            alu_res = acc_q + alu_b;
            alu_ovf = (acc_q[MSB] == alu_b[MSB]) && (alu_res[MSB] != acc_q[MSB]);
        end
    end

    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        acc_wr = 1'b0;
        if (i_wrAcc) begin
            case (i_selA)
                SEL_A_MEM: begin
                    acc_d  = mem_data;
                    ovf_d  = 1'b0;
                    acc_wr = 1'b1;
                end
                SEL_A_IMM: begin
                    acc_d  = imm;
                    ovf_d  = 1'b0;
                    acc_wr = 1'b1;
                end
                SEL_A_ALU: begin
                    acc_d  = alu_res;
                    ovf_d  = alu_ovf;
                    acc_wr = 1'b1;
                end
                default: begin
                    // Reserved select: accumulator and flags hold.
                end
            endcase
        end
        zero_d = acc_wr ? (acc_d == '0) : zero_q;
        neg_d  = acc_wr ? acc_d[MSB]    : neg_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q  <= '0;
            zero_q <= 1'b1;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_acc  = acc_q;
    assign o_zero = zero_q;
    assign o_neg  = neg_q;
    assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_bip_datapath.sv
// tb/tb_bip_datapath.sv - self-checking bench for bip_datapath with behavioural reference model
module tb_bip_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] operand = '0;
    logic [1:0]  sel_a = '0;
    logic        sel_b = 1'b0;
    logic        wr_acc = 1'b0;
    logic        op = 1'b0;
    logic        wr_ram = 1'b0;
    logic        rd_ram = 1'b0;
    logic [15:0] acc;
    logic        zero, neg, ovf;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_ram [2048];
    logic [15:0] m_acc = '0;
    logic        m_zero = 1'b0, m_neg = 1'b0, m_ovf = 1'b0;
    logic        m_valid = 1'b0;

    always #5 clk = ~clk;

    bip_datapath dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_operand (operand),
        .i_selA    (sel_a),
        .i_selB    (sel_b),
        .i_wrAcc   (wr_acc),
        .i_op      (op),
        .i_wrRam   (wr_ram),
        .i_rdRam   (rd_ram),
        .o_acc     (acc),
        .o_zero    (zero),
        .o_neg     (neg),
        .o_ovf     (ovf)
    );

    function automatic int to_int16(input logic [15:0] v);
        return v[15] ? int'(v) - 65536 : int'(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: signed integer arithmetic on whole instructions.
    always @(posedge clk) begin
        int          a_s, b_s, imm_s, r_s;
        logic [15:0] mem_v, new_v;
        if (rst) begin
            m_acc = '0; m_zero = 1'b1; m_neg = 1'b0; m_ovf = 1'b0; m_valid = 1'b1;
        end else begin
            mem_v = rd_ram ? m_ram[operand] : 16'h0000;
            imm_s = operand[10] ? int'(operand) - 2048 : int'(operand);
            b_s   = sel_b ? imm_s : to_int16(mem_v);
            a_s   = to_int16(m_acc);
            r_s   = op ? a_s - b_s : a_s + b_s;
            if (wr_ram) m_ram[operand] = m_acc;
            if (wr_acc && sel_a != 2'd3) begin
                case (sel_a)
                    2'd0:    begin new_v = mem_v;       m_ovf = 1'b0; end
                    2'd1:    begin new_v = 16'(imm_s);  m_ovf = 1'b0; end
                    default: begin new_v = 16'(r_s);    m_ovf = (r_s > 32767) || (r_s < -32768); end
                endcase
                m_acc  = new_v;
                m_zero = (to_int16(new_v) == 0);
                m_neg  = (to_int16(new_v) < 0);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_acc",  acc,         m_acc);
            chk("model_zero", {15'd0, zero}, {15'd0, m_zero});
            chk("model_neg",  {15'd0, neg},  {15'd0, m_neg});
            chk("model_ovf",  {15'd0, ovf},  {15'd0, m_ovf});
        end
    end

    task automatic step(input logic r, input logic [1:0] sa, input logic sb, input logic wa,
                        input logic o, input logic wr, input logic rd, input logic [10:0] opnd);
        rst = r; sel_a = sa; sel_b = sb; wr_acc = wa; op = o; wr_ram = wr; rd_ram = rd; operand = opnd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ldi(input logic [10:0] v);  step(0, 2'd1, 0, 1, 0, 0, 0, v); endtask
    task automatic sto(input logic [10:0] a);  step(0, 2'd0, 0, 0, 0, 1, 0, a); endtask
    task automatic ld(input logic [10:0] a);   step(0, 2'd0, 0, 1, 0, 0, 1, a); endtask
    task automatic addi(input logic [10:0] v); step(0, 2'd2, 1, 1, 0, 0, 0, v); endtask
    task automatic addm(input logic [10:0] a); step(0, 2'd2, 0, 1, 0, 0, 1, a); endtask
    task automatic subm(input logic [10:0] a); step(0, 2'd2, 0, 1, 1, 0, 1, a); endtask
    task automatic dbl();                      sto(11'd100); addm(11'd100); endtask

    initial begin
        logic [10:0] rnd_op;
        logic        r, rd;

        // Reset then LDI
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_acc", acc, 16'h0000);
        chk("rst_zero", {15'd0, zero}, 16'd1);
        chk("rst_neg", {15'd0, neg}, 16'd0);
        chk("rst_ovf", {15'd0, ovf}, 16'd0);
        ldi(11'h7FF);
        chk("ldi_7ff_acc", acc, 16'hFFFF);
        chk("ldi_7ff_neg", {15'd0, neg}, 16'd1);
        chk("ldi_7ff_zero", {15'd0, zero}, 16'd0);
        chk("ldi_7ff_ovf", {15'd0, ovf}, 16'd0);
        ldi(11'h3FF);
        chk("ldi_3ff_acc", acc, 16'h03FF);

        // Give the low 64 words known contents for the random phase.
        for (int i = 0; i < 64; i++) begin
            ldi(11'($urandom));
            sto(11'(i));
        end

        // STO/LD round trip
        ldi(11'h123);
        sto(11'd5);
        ldi(11'd0);
        chk("ldi0_zero", {15'd0, zero}, 16'd1);
        ld(11'd5);
        chk("ld5_acc", acc, 16'h0123);

        // ADDI overflow
        ldi(11'h3FF);
        repeat (31) addi(11'h3FF);
        addi(11'd31);
        chk("build_7fff", acc, 16'h7FFF);
        addi(11'd1);
        chk("addi_ovf_acc", acc, 16'h8000);
        chk("addi_ovf_ovf", {15'd0, ovf}, 16'd1);
        chk("addi_ovf_neg", {15'd0, neg}, 16'd1);
        ldi(11'd3);
        chk("ldi3_clears_ovf", {15'd0, ovf}, 16'd0);

        // SUB from memory
        ldi(11'd5);
        sto(11'd10);
        subm(11'd10);
        chk("sub_acc", acc, 16'h0000);
        chk("sub_zero", {15'd0, zero}, 16'd1);
        chk("sub_ovf", {15'd0, ovf}, 16'd0);

        // Read/write collision
        ldi(11'h2AA);
        repeat (4) dbl();
        addi(11'hA);
        dbl();
        dbl();
        addi(11'd2);
        chk("build_aaaa", acc, 16'hAAAA);
        sto(11'd3);
        ldi(11'h2AA);
        repeat (4) dbl();
        addi(11'hA);
        dbl();
        addi(11'd1);
        chk("build_5555", acc, 16'h5555);
        step(0, 2'd0, 0, 1, 0, 1, 1, 11'd3);
        chk("collide_acc", acc, 16'hAAAA);
        ld(11'd3);
        chk("collide_ram", acc, 16'h5555);

        // Reset mid-stream, reserved select, hold
        ldi(11'h7FF);
        step(1, 2'd2, 1, 1, 0, 1, 0, 11'd1);
        chk("midrst_acc", acc, 16'h0000);
        chk("midrst_zero", {15'd0, zero}, 16'd1);
        chk("midrst_neg", {15'd0, neg}, 16'd0);
        ld(11'd1);
        ldi(11'h7FF);
        step(0, 2'd3, 1, 1, 0, 0, 0, 11'd5);
        chk("sel3_acc", acc, 16'hFFFF);
        chk("sel3_neg", {15'd0, neg}, 16'd1);
        repeat (5) step(0, 2'd2, 1, 0, 0, 0, 0, 11'd7);
        chk("hold_acc", acc, 16'hFFFF);
        chk("hold_neg", {15'd0, neg}, 16'd1);

        // Randomised instruction mix
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 1) == 1) rnd_op = 11'($urandom_range(0, 63));
            else                           rnd_op = 11'($urandom);
            rd = (rnd_op < 11'd64) ? 1'($urandom) : 1'b0;
            r  = ($urandom_range(0, 49) == 0);
            step(r, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 (rnd_op < 11'd64) ? 1'($urandom) : 1'b0, rd, rnd_op);
        end

        step(0, 0, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bip_datapath.md
Name: bip_datapath

Overview:
- Execution datapath of the BIP core. It sits directly downstream of the control unit and consumes its per-instruction strobes (selA, selB, wrAcc, op, wrRam, rdRam) together with the instruction operand field.
- Holds the accumulator, the add/sub ALU, the immediate sign-extender, status flags and the data memory.
- Executes every instruction in exactly one clock cycle.

Parameters:
- NB_DATA, 16, accumulator / data-memory word width.
- NB_ADDR, 11, operand field width; also the data-memory address width.
- NB_DECODER_SEL_A, 2, selA width.
- RAM_DEPTH, 2048, data-memory words; must be ≤ 2**NB_ADDR.

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_operand  in  NB_ADDR  instruction operand field: immediate or data address.
- i_selA  in  NB_DECODER_SEL_A  accumulator input select: 0 = memory data, 1 = sign-extended immediate, 2 = ALU result, 3 = reserved.
- i_selB  in  1  ALU B-operand select: 0 = memory data, 1 = sign-extended immediate.
- i_wrAcc  in  1  accumulator write enable.
- i_op  in  1  ALU operation: 0 = add, 1 = subtract (acc − B).
- i_wrRam  in  1  data-memory write enable.
- i_rdRam  in  1  data-memory read enable.
- o_acc  out  NB_DATA  accumulator value.
- o_zero  out  1  registered flag: last written accumulator value == 0.
- o_neg  out  1  registered flag: MSB of last written accumulator value.
- o_ovf  out  1  registered flag: signed overflow of last ALU write.

Behaviour:
- Reset: on a rising edge with i_rst=1, o_acc=0, o_zero=1, o_neg=0, o_ovf=0. Reset overrides all strobes in that cycle. Data-memory contents are not cleared, and no RAM write occurs during a reset cycle.
- Sign extension: imm = i_operand replicated MSB to NB_DATA bits; e.g. 11'h7FF → 16'hFFFF, 11'h3FF → 16'h03FF.
- Memory read:
  - Combinational (asynchronous): mem_data = RAM[i_operand] when i_rdRam=1, else 0.
  - Addresses ≥ RAM_DEPTH read 0.
- Memory write:
  - RAM[i_operand] ← o_acc on the rising edge when i_wrRam=1.
  - Addresses ≥ RAM_DEPTH are ignored.
  - Same-cycle i_rdRam and i_wrRam at the same address: the read returns the pre-write (old) data.
- ALU:
  - B = i_selB ? imm : mem_data.
  - res = i_op ? acc − B : acc + B, modulo 2**NB_DATA.
  - Signed overflow: add → operands same sign and result sign differs; sub → operands differ in sign and result sign differs from acc.
- Accumulator update, on the rising edge when i_wrAcc=1:
  - selA 0 → mem_data; selA 1 → imm; selA 2 → res.
  - selA 3 → no change, flags unchanged.
- Flags:
  - On any accumulator write, o_zero and o_neg are recomputed from the new value.
  - o_ovf is set from the ALU overflow when selA=2 and cleared when selA is 0 or 1.
- Hold: with i_wrAcc=0, the accumulator and all flags hold.
- Latency: o_acc and flags reflect an instruction one cycle after its strobes are presented; the result is usable by the next instruction with no stall.
- Store after write: a store presented in the cycle after an accumulator write stores the new value.
- HLT: all strobes are low, so the datapath holds state indefinitely.
- Mid-operation reset: state returns to reset values on that edge; the strobes of that cycle are discarded.

Decomposition:
- Shared package bip_pkg holds:
  - opcode constants (HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI = 0..7);
  - selA encodings SEL_A_MEM=0, SEL_A_IMM=1, SEL_A_ALU=2;
  - OP_ADD=0, OP_SUB=1.
- One sub-module, bip_data_memory: single-port, asynchronous read, synchronous write, RAM_DEPTH × NB_DATA, with the out-of-range rules above.
- ALU and sign extension stay inline.

Test Plan:
1. Reset then LDI: i_rst=1 for 2 cycles, then selA=1, wrAcc=1, operand=11'h7FF → o_acc=16'hFFFF, o_neg=1, o_zero=0, o_ovf=0 on the next cycle.
2. STO/LD round trip: acc=16'h0123; wrRam=1, operand=5; then LDI 0; then rdRam=1, selA=0, wrAcc=1, operand=5 → o_acc=16'h0123. RAM[5] is unchanged by the intervening LDI.
3. ADDI overflow: acc=16'h7FFF; selA=2, selB=1, op=0, operand=1, wrAcc=1 → o_acc=16'h8000, o_ovf=1, o_neg=1. A following LDI 3 clears o_ovf.
4. SUB from memory:
   - Setup: RAM[10]=16'h0005, acc=16'h0005.
   - Apply: rdRam=1, selB=0, op=1, selA=2, wrAcc=1, operand=10.
   - Expect: o_acc=0, o_zero=1, o_ovf=0.
5. Read/write collision: RAM[3]=16'hAAAA, acc=16'h5555; same cycle wrRam=1, rdRam=1, selA=0, wrAcc=1, operand=3 → o_acc=16'hAAAA, RAM[3]=16'h5555 afterwards.
6. Reset mid-stream plus reserved/hold:
   - i_rst asserted together with an ADDI → o_acc=0, o_zero=1, flags reset.
   - selA=3 with wrAcc=1 → o_acc and flags unchanged.
   - wrAcc=0 for 5 cycles → values held.
